// File: rtl/instr_fetch.sv
// instr_fetch: PC owner feeding a synchronous ROM, valid/ready output with redirect and halt
module instr_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int unsigned RESET_PC = 1,
  parameter logic [5:0] HALT_OPCODE = 6'b010001
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  halted
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t st, st_nxt;
  logic [ADDR_WIDTH-1:0] pc, req_pc;
  logic req_valid, move, halt_hit, issue, redir;
  assign redir = redirect && st == RUN;
  assign move = req_valid && (!instr_valid || instr_ready);
  assign halt_hit = move && rom_q[DATA_WIDTH-1 -: 6] == HALT_OPCODE;
  always_ff @(posedge clk)
    st <= rst ? RUN : st_nxt;
  always_comb
    st_nxt = (st == RUN && !redir && halt_hit) ? HALTED : st;
  // Without a new issue the in-flight address is replayed so rom_q survives stalls
  always_comb begin
    issue = st == RUN && (!req_valid || move) && !halt_hit;
    rom_addr = redir ? redirect_pc : issue ? pc : req_pc;
    halted = st == HALTED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= ADDR_WIDTH'(RESET_PC);
      req_valid <= 1'b0;
      req_pc <= '0;
      instr <= '0;
      instr_pc <= '0;
      instr_valid <= 1'b0;
    end else if (redir) begin
      instr_valid <= 1'b0;
      req_valid <= 1'b1;
      req_pc <= redirect_pc;
      pc <= redirect_pc + 1'b1;
    end else begin
      if (move) begin
        instr <= rom_q;
        instr_pc <= req_pc;
        instr_valid <= 1'b1;
      end else if (instr_valid && instr_ready) instr_valid <= 1'b0;
      if (issue) begin
        req_valid <= 1'b1;
        req_pc <= pc;
        pc <= pc + 1'b1;
      end else if (move) req_valid <= 1'b0;
    end
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly upstream of the synchronous instruction ROM. Owns the program counter, drives the ROM address, captures the ROM word one cycle later, and presents it with its address to the decode stage over a valid/ready handshake. Supports redirects (branch/jump) from downstream and stops fetching after delivering a halt instruction.

## Interface
- DATA_WIDTH, 32, instruction word width (matches ROM word)
- ADDR_WIDTH, 9, ROM address / PC width
- RESET_PC, 1, PC loaded at reset (first program word)
- HALT_OPCODE, 6'b010001, value of instr[31:26] that halts fetch

- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- rom_addr  output  ADDR_WIDTH  address to ROM (combinational)
- rom_q  input  DATA_WIDTH  ROM registered read data, word for the address presented on the previous cycle
- instr  output  DATA_WIDTH  fetched instruction (registered)
- instr_pc  output  ADDR_WIDTH  address of instr (registered)
- instr_valid  output  1  instr/instr_pc hold a valid instruction
- instr_ready  input  1  decode accepts instr this cycle
- redirect  input  1  one-cycle pulse: discard fetched/in-flight words, fetch from redirect_pc
- redirect_pc  input  ADDR_WIDTH  redirect target
- halted  output  1  high in HALTED state

## Operation
- Internal state: pc (next address to issue), req_valid/req_pc (ROM read in flight), output register, FSM {RUN, HALTED}.
- Reset: pc=RESET_PC, req_valid=0, req_pc=0, instr=0, instr_pc=0, instr_valid=0, FSM=RUN, halted=0. rom_addr is don't-care while rst is high; no issue occurs.
- Per cycle (RUN, no redirect):
  - move = req_valid && (!instr_valid || instr_ready): rom_q, req_pc captured into instr, instr_pc; instr_valid<=1.
  - If !move && instr_valid && instr_ready: instr_valid<=0.
  - halt_hit = move && rom_q[31:26]==HALT_OPCODE.
  - issue = (!req_valid || move) && !halt_hit.
  - issue: rom_addr=pc, req_valid<=1, req_pc<=pc, pc<=pc+1 modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0).
  - !issue: rom_addr=req_pc (re-reads the in-flight word so rom_q stays valid across stalls); if move, req_valid<=0.
- halt_hit: halt instruction is delivered normally; FSM<=HALTED; no further issue. In HALTED: no issue, rom_addr=req_pc, remaining output handshake completes normally, halted=1. Only rst leaves HALTED.
- Redirect (RUN): overrides everything this cycle. instr_valid<=0 (output squashed even if instr_ready), no capture, rom_addr=redirect_pc, req_valid<=1, req_pc<=redirect_pc, pc<=redirect_pc+1 (wrapping).
- Redirect in HALTED: ignored.
- Redirect simultaneous with halt_hit: redirect wins, FSM stays RUN.
- rst mid-operation: all state returns to reset values at that edge regardless of redirect/handshake.

## Timing
- Fetch latency: address issued in cycle t, word on rom_q in t+1, instr_valid in t+2.
- First instruction after reset: instr_valid high on the 2nd rising edge after rst deasserts (instr_pc=RESET_PC).
- Redirect pulse in cycle t: target word instr_valid in t+2; instr_valid low in t+1.
- Throughput: one instruction per cycle while instr_ready=1.
- Stall: instr, instr_pc stable and instr_valid held while instr_valid && !instr_ready; pc does not advance; no word lost or duplicated.
- rom_addr depends combinationally on instr_ready, redirect, redirect_pc, rom_q (through halt_hit).

## Test plan
- Reset then instr_ready=1, ROM words 1..5 non-halt: instr_pc sequence 1,2,3,4,5 on consecutive cycles, first valid 2 cycles after reset release.
- instr_ready low for 3 cycles while instr_pc=3: instr/instr_pc held at word 3; after release stream continues 4,5 with no gap, skip or duplicate.
- Redirect pulse to 0x010 while instr_pc=4: instr_valid low next cycle, then instr_pc=0x010, 0x011; words 5/6 never delivered.
- Word 6 = halt opcode: word 6 delivered, halted=1 the next cycle, no instr_pc 7 ever appears, redirect afterwards ignored.
- RESET_PC=511 (ADDR_WIDTH=9): instr_pc sequence 511, 0, 1.
- Assert rst while instr_valid=1 and stalled: all outputs zero next cycle, fetch restarts at RESET_PC.
